// File: rtl/freelist_checkpoint_ctrl_pkg.sv
// Shared sizing constants and types for the branch checkpoint controller.
package freelist_checkpoint_ctrl_pkg;
  localparam int BRANCH_STACK_DEPTH = 4;
  localparam int PHYS_REG_SZ_R10K   = 64;
  localparam int SUPERSCALAR_N      = 3;
  localparam int NUM_SCALAR_BITS    = $clog2(SUPERSCALAR_N + 1);
  localparam int PHYS_REG_IDX_W     = $clog2(PHYS_REG_SZ_R10K);

  typedef logic [PHYS_REG_IDX_W-1:0]              PHYS_REG_IDX;
  typedef logic [$clog2(BRANCH_STACK_DEPTH)-1:0] BRANCH_TAG;

  // Distance from a to b around a ring of 2**w slots.
  function automatic logic [7:0] ring_dist(input logic [7:0] a, input logic [7:0] b, input int w);
    logic [7:0] d;
    d = b - a;
    return d & 8'((1 << w) - 1);
  endfunction
endpackage

// File: rtl/freelist_checkpoint_ctrl_retire_mask_gen.sv
// Turns the lowest cnt retiring register indices into a one-hot-OR free mask.
module retire_mask_gen
  import freelist_checkpoint_ctrl_pkg::*;
#(
  parameter int N     = SUPERSCALAR_N,
  parameter int PREGS = PHYS_REG_SZ_R10K,
  parameter int IW    = $clog2(PREGS),
  parameter int CW    = $clog2(N + 1)
) (
  input  logic [N-1:0][IW-1:0] idx,
  input  logic [CW-1:0]        cnt,
  output logic [PREGS-1:0]     mask
);
  // OR in one bit per valid retiring slot; only the lowest cnt slots count.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      if (CW'(i) < cnt) mask[idx[i]] = 1'b1;
  end
endmodule

// File: rtl/freelist_checkpoint_ctrl.sv
// Branch checkpoint stack for the physical-register free list: snapshot on
// dispatch, keep snapshots current with retire frees, restore on mispredict.
module freelist_checkpoint_ctrl
  import freelist_checkpoint_ctrl_pkg::*;
#(
  parameter int DEPTH = BRANCH_STACK_DEPTH,
  parameter int PREGS = PHYS_REG_SZ_R10K,
  parameter int N     = SUPERSCALAR_N,
  parameter int IW    = $clog2(PREGS),
  parameter int CW    = $clog2(N + 1),
  parameter int TW    = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ckpt_req,
  input  logic [PREGS-1:0]     ckpt_free_list,
  output logic                 ckpt_gnt,
  output logic [TW-1:0]        ckpt_tag,
  input  logic                 resolve_valid,
  input  logic [TW-1:0]        resolve_tag,
  input  logic                 resolve_mispredict,
  input  logic [N-1:0][IW-1:0] phys_reg_retiring,
  input  logic [CW-1:0]        num_retiring_valid,
  output logic [PREGS-1:0]     free_list_restore,
  output logic                 restore_flag,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic [TW:0]          num_live
);
  logic [TW:0]                  head, tail;
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0][PREGS-1:0]  snap;
  logic [PREGS-1:0]             retire_mask;
  logic [DEPTH-1:0]             kill;
  logic [TW-1:0]                h_idx, t_idx, mis_off;
  logic [TW:0]                  mis_tail;
  logic                         mis_in, mis_ok, cor_ok, head_adv;

  retire_mask_gen #(.N(N), .PREGS(PREGS), .IW(IW), .CW(CW)) u_mask (
    .idx  (phys_reg_retiring),
    .cnt  (num_retiring_valid),
    .mask (retire_mask)
  );

  assign h_idx       = head[TW-1:0];
  assign t_idx       = tail[TW-1:0];
  assign stack_empty = (head == tail);
  assign stack_full  = (h_idx == t_idx) && (head[TW] != tail[TW]);
  assign num_live    = tail - head;

  // A mispredict in the same cycle blocks allocation; the request is retried.
  assign mis_in   = resolve_valid & resolve_mispredict;
  assign mis_ok   = mis_in & valid[resolve_tag];
  assign cor_ok   = resolve_valid & ~resolve_mispredict & valid[resolve_tag];
  assign ckpt_gnt = reset & ckpt_req & ~stack_full & ~mis_in;
  assign ckpt_tag = t_idx;
  assign head_adv = ~stack_empty & ~valid[h_idx];

  // New tail keeps the wrap bit consistent by stepping forward from head.
  assign mis_off  = resolve_tag - h_idx;
  assign mis_tail = head + {1'b0, mis_off};

  // Slots at or beyond the mispredicted one (in age order) are squashed.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++)
      kill[i] = (TW'(TW'(i) - h_idx) >= mis_off);
  end

  // Head drains one hole per cycle; tail allocates or rewinds on mispredict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + {{TW{1'b0}}, head_adv};
      if (mis_ok)        tail <= mis_tail;
      else if (ckpt_gnt) tail <= tail + (TW+1)'(1);
    end
  end

  // Per-slot valid bits and snapshots, merged with retire frees every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      snap  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mis_ok && kill[i])                       valid[i] <= 1'b0;
        else if (cor_ok && resolve_tag == TW'(i))    valid[i] <= 1'b0;
        else if (ckpt_gnt && t_idx == TW'(i))        valid[i] <= 1'b1;

        if (ckpt_gnt && t_idx == TW'(i))             snap[i] <= ckpt_free_list | retire_mask;
        else if (valid[i])                           snap[i] <= snap[i] | retire_mask;
      end
    end
  end

  // One-cycle restore strobe; the restored list holds until the next restore.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      restore_flag      <= 1'b0;
      free_list_restore <= '0;
    end else begin
      restore_flag <= mis_ok;
      if (mis_ok) free_list_restore <= snap[resolve_tag] | retire_mask;
    end
  end
endmodule

// File: tb/tb_freelist_checkpoint_ctrl.sv
// Randomized + directed bench with an integer-pointer reference model.
module tb_freelist_checkpoint_ctrl;
  localparam int D = 4;

  logic             clock, reset;
  logic             ckpt_req;
  logic [63:0]      ckpt_free_list;
  logic             ckpt_gnt;
  logic [1:0]       ckpt_tag;
  logic             resolve_valid, resolve_mispredict;
  logic [1:0]       resolve_tag;
  logic [2:0][5:0]  phys_reg_retiring;
  logic [1:0]       num_retiring_valid;
  logic [63:0]      free_list_restore;
  logic             restore_flag, stack_full, stack_empty;
  logic [2:0]       num_live;

  int errors = 0;
  int checks = 0;

  // Model: unbounded occupancy counters plus per-slot contents.
  int          mh, mt;
  bit          mv[D];
  logic [63:0] ms[D];
  bit          rflag;
  logic [63:0] rdata;

  freelist_checkpoint_ctrl dut (
    .clock(clock), .reset(reset), .ckpt_req(ckpt_req), .ckpt_free_list(ckpt_free_list),
    .ckpt_gnt(ckpt_gnt), .ckpt_tag(ckpt_tag), .resolve_valid(resolve_valid),
    .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
    .phys_reg_retiring(phys_reg_retiring), .num_retiring_valid(num_retiring_valid),
    .free_list_restore(free_list_restore), .restore_flag(restore_flag),
    .stack_full(stack_full), .stack_empty(stack_empty), .num_live(num_live)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task model_clear();
    mh = 0; mt = 0; rflag = 0; rdata = '0;
    for (int i = 0; i < D; i++) begin mv[i] = 0; ms[i] = '0; end
  endtask

  task idle();
    ckpt_req = 0; ckpt_free_list = '0; resolve_valid = 0; resolve_tag = 0;
    resolve_mispredict = 0; phys_reg_retiring = '0; num_retiring_valid = 0;
  endtask

  task model_update();
    bit          ov[D];
    logic [63:0] os[D];
    logic [63:0] mask;
    bit          mis, cor, gnt, adv;
    int          rt, k, nt;
    mask = '0;
    for (int i = 0; i < int'(num_retiring_valid); i++) mask[phys_reg_retiring[i]] = 1'b1;
    for (int i = 0; i < D; i++) begin ov[i] = mv[i]; os[i] = ms[i]; end
    rt  = int'(resolve_tag);
    mis = resolve_valid && resolve_mispredict && ov[rt];
    cor = resolve_valid && !resolve_mispredict && ov[rt];
    gnt = ckpt_req && (mt - mh) != D && !(resolve_valid && resolve_mispredict);
    for (int i = 0; i < D; i++) if (ov[i]) ms[i] = os[i] | mask;
    rflag = mis;
    if (mis) rdata = os[rt] | mask;
    if (cor) mv[rt] = 0;
    adv = (mh != mt) && !ov[mh % D];
    nt = mt;
    if (mis) begin
      k = (rt - (mh % D) + D) % D;
      for (int p = mh + k; p < mt; p++) mv[p % D] = 0;
      nt = mh + k;
    end
    if (gnt) begin
      ms[mt % D] = ckpt_free_list | mask;
      mv[mt % D] = 1;
      nt = mt + 1;
    end
    mh = mh + int'(adv);
    mt = nt;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task step();
    bit exp_gnt;
    exp_gnt = ckpt_req && (mt - mh) != D && !(resolve_valid && resolve_mispredict);
    #1;
    checks++;
    if (ckpt_gnt !== exp_gnt) begin
      errors++; $display("FAIL gnt: got %0b want %0b", ckpt_gnt, exp_gnt);
    end
    if (exp_gnt) begin
      checks++;
      if (ckpt_tag !== 2'(mt % D)) begin
        errors++; $display("FAIL tag: got %0d want %0d", ckpt_tag, mt % D);
      end
    end
    @(posedge clock);
    model_update();
    @(negedge clock);
    checks++;
    if (restore_flag !== rflag) begin
      errors++; $display("FAIL restore_flag: got %0b want %0b", restore_flag, rflag);
    end
    checks++;
    if (free_list_restore !== rdata) begin
      errors++; $display("FAIL restore_data: got %h want %h", free_list_restore, rdata);
    end
    checks++;
    if (num_live !== 3'(mt - mh) || stack_full !== ((mt - mh) == D) || stack_empty !== (mt == mh)) begin
      errors++;
      $display("FAIL occupancy: got live=%0d full=%0b empty=%0b want live=%0d", num_live, stack_full, stack_empty, mt - mh);
    end
  endtask

  task do_reset();
    idle();
    reset = 0;
    #2;
    @(negedge clock);
    reset = 1;
    model_clear();
  endtask

  task req(input logic [63:0] fl);
    idle(); ckpt_req = 1; ckpt_free_list = fl; step();
  endtask

  task resolve(input int tag, input bit mp);
    idle(); resolve_valid = 1; resolve_tag = 2'(tag); resolve_mispredict = mp; step();
  endtask

  task test_reset();
    idle();
    reset = 0;
    ckpt_req = 1;
    #3;
    checks++;
    if (stack_empty !== 1 || stack_full !== 0 || num_live !== 0 || ckpt_gnt !== 0 ||
        ckpt_tag !== 0 || restore_flag !== 0 || free_list_restore !== '0) begin
      errors++; $display("FAIL reset_state: empty=%0b full=%0b live=%0d gnt=%0b", stack_empty, stack_full, num_live, ckpt_gnt);
    end
    do_reset();
  endtask

  task test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) req(64'($urandom) << 32 | 64'($urandom));
    checks++;
    if (stack_full !== 1 || num_live !== 3'd4) begin
      errors++; $display("FAIL fill: got full=%0b live=%0d want 1/4", stack_full, num_live);
    end
    req(64'h1);  // fifth request: model expects no grant
  endtask

  task test_restore();
    do_reset();
    req(64'h0F);
    idle(); step();
    idle(); phys_reg_retiring[0] = 6'd8; num_retiring_valid = 1; step();
    resolve(0, 1);
    checks++;
    if (restore_flag !== 1 || free_list_restore !== 64'h10F) begin
      errors++; $display("FAIL restore_value: got flag=%0b data=%h want 1/10f", restore_flag, free_list_restore);
    end
    idle(); step();
    checks++;
    if (restore_flag !== 0 || stack_empty !== 1) begin
      errors++; $display("FAIL restore_end: got flag=%0b empty=%0b want 0/1", restore_flag, stack_empty);
    end
  endtask

  task test_holes();
    do_reset();
    req(64'hA0); req(64'hB0); req(64'hC0);
    resolve(1, 0);
    resolve(2, 1);
    checks++;
    if (free_list_restore !== 64'hC0 || num_live !== 3'd2) begin
      errors++; $display("FAIL holes_restore: got data=%h live=%0d want c0/2", free_list_restore, num_live);
    end
    resolve(0, 0);
    checks++;
    if (num_live !== 3'd2) begin errors++; $display("FAIL holes_live_a: got %0d want 2", num_live); end
    idle(); step();
    checks++;
    if (num_live !== 3'd1) begin errors++; $display("FAIL holes_live_b: got %0d want 1", num_live); end
    idle(); step();
    checks++;
    if (num_live !== 3'd0) begin errors++; $display("FAIL holes_live_c: got %0d want 0", num_live); end
  endtask

  task test_same_cycle();
    do_reset();
    req(64'h3); req(64'h30);
    idle();
    ckpt_req = 1; ckpt_free_list = 64'hFF;
    resolve_valid = 1; resolve_tag = 0; resolve_mispredict = 1;
    phys_reg_retiring[0] = 6'd5; phys_reg_retiring[1] = 6'd6; phys_reg_retiring[2] = 6'd40;
    num_retiring_valid = 2;
    step();
    checks++;
    if (free_list_restore[6:5] !== 2'b11 || free_list_restore[40] !== 1'b0) begin
      errors++; $display("FAIL same_cycle_bits: got %h want bits 5,6 set, 40 clear", free_list_restore);
    end
  endtask

  task test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) req(64'(i + 1));
    for (int i = 0; i < 4; i++) resolve(i, 0);
    for (int i = 0; i < 4; i++) begin idle(); step(); end
    checks++;
    if (stack_empty !== 1) begin errors++; $display("FAIL wrap_empty: got %0b want 1", stack_empty); end
    for (int i = 0; i < 4; i++) req(64'(16 << i));
    checks++;
    if (stack_full !== 1 || num_live !== 3'd4) begin
      errors++; $display("FAIL wrap_full: got full=%0b live=%0d want 1/4", stack_full, num_live);
    end
    resolve(2, 1);  // restore from a slot filled on the second lap
  endtask

  task test_async_reset();
    do_reset();
    req(64'h55);
    idle();
    resolve_valid = 1; resolve_tag = 0; resolve_mispredict = 1;
    #1;
    @(posedge clock);
    #2;
    checks++;
    if (restore_flag !== 1) begin errors++; $display("FAIL async_pre: got flag %0b want 1", restore_flag); end
    idle();
    ckpt_req = 1;
    reset = 0;
    #1;
    checks++;
    if (restore_flag !== 0 || free_list_restore !== '0 || stack_empty !== 1 || stack_full !== 0 ||
        num_live !== 0 || ckpt_gnt !== 0 || ckpt_tag !== 0) begin
      errors++; $display("FAIL async_reset: got flag=%0b data=%h empty=%0b gnt=%0b", restore_flag, free_list_restore, stack_empty, ckpt_gnt);
    end
    @(negedge clock);
    reset = 1;
    model_clear();
    for (int i = 0; i < 3; i++) begin idle(); step(); end
  endtask

  task test_random();
    int live;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      live = mt - mh;
      ckpt_req = ($urandom_range(0, 2) != 0);
      ckpt_free_list = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 2) == 0) begin
        resolve_valid = 1;
        resolve_tag = (live > 0) ? 2'((mh + $urandom_range(0, live - 1)) % D) : 2'($urandom_range(0, 3));
        resolve_mispredict = ($urandom_range(0, 5) == 0);
      end
      for (int i = 0; i < 3; i++) phys_reg_retiring[i] = 6'($urandom_range(0, 63));
      num_retiring_valid = 2'($urandom_range(0, 3));
      step();
    end
  endtask

  initial begin
    reset = 0;
    idle();
    model_clear();
    test_reset();
    test_fill();
    test_restore();
    test_holes();
    test_same_cycle();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
